// File: rtl/lm32_seq_divider_if.sv
// Request/response and external adder/subtractor signals of the sequential divider.
// The divider takes the slave side; the requester plus adder model take the master side.
interface lm32_seq_divider_if;
    logic        start_i;
    logic        signed_i;
    logic        kill_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic        dbz_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic [31:0] addsub_a_o;
    logic [31:0] addsub_b_o;
    logic        addsub_cin_o;
    logic        addsub_add_sub_o;
    logic [31:0] addsub_result_i;
    logic        addsub_cout_i;

    modport slave (
        input  start_i, signed_i, kill_i, dividend_i, divisor_i,
        input  addsub_result_i, addsub_cout_i,
        output busy_o, done_o, dbz_o, quotient_o, remainder_o,
        output addsub_a_o, addsub_b_o, addsub_cin_o, addsub_add_sub_o
    );

    modport master (
        output start_i, signed_i, kill_i, dividend_i, divisor_i,
        output addsub_result_i, addsub_cout_i,
        input  busy_o, done_o, dbz_o, quotient_o, remainder_o,
        input  addsub_a_o, addsub_b_o, addsub_cin_o, addsub_add_sub_o
    );
endinterface

// File: rtl/lm32_seq_divider.sv
// Sequential 32-bit restoring divider (signed/unsigned), one quotient bit per cycle,
// sharing an external adder/subtractor for the trial subtraction.
module lm32_seq_divider #(
    parameter logic [31:0] DBZ_QUOTIENT = 32'hFFFFFFFF
) (
    input logic               clk_i,
    input logic               rst_i,
    lm32_seq_divider_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

    state_e      state_q;
    logic [31:0] dividend_q;
    logic [31:0] divisor_q;
    logic        op_signed_q;
    logic [31:0] q_q;
    logic [31:0] r_q;
    logic [31:0] d_q;
    logic [4:0]  cnt_q;
    logic        quot_neg_q;
    logic        rem_neg_q;
    logic [31:0] quotient_q;
    logic [31:0] remainder_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;

    logic [31:0] shift_s;
    logic        accept;
    logic [31:0] abs_dividend;
    logic [31:0] abs_divisor;

    // R[31] is bit 32 of the shifted partial remainder, so S >= 2^32 > D always accepts.
    assign shift_s = {r_q[30:0], q_q[31]};
    assign accept  = bus.addsub_cout_i | r_q[31];

    assign abs_dividend = (op_signed_q && dividend_q[31]) ? -dividend_q : dividend_q;
    assign abs_divisor  = (op_signed_q && divisor_q[31])  ? -divisor_q  : divisor_q;

    always_comb begin
        bus.addsub_a_o       = 32'd0;
        bus.addsub_b_o       = 32'd0;
        bus.addsub_cin_o     = 1'b1;
        bus.addsub_add_sub_o = 1'b0;
        if (state_q == StIter) begin
            bus.addsub_a_o = shift_s;
            bus.addsub_b_o = d_q;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.dbz_o       = dbz_q;
    assign bus.quotient_o  = quotient_q;
    assign bus.remainder_o = remainder_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            dividend_q  <= 32'd0;
            divisor_q   <= 32'd0;
            op_signed_q <= 1'b0;
            q_q         <= 32'd0;
            r_q         <= 32'd0;
            d_q         <= 32'd0;
            cnt_q       <= 5'd0;
            quot_neg_q  <= 1'b0;
            rem_neg_q   <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start_i && !bus.kill_i) begin
                        dividend_q  <= bus.dividend_i;
                        divisor_q   <= bus.divisor_i;
                        op_signed_q <= bus.signed_i;
                        busy_q      <= 1'b1;
                        state_q     <= StPrep;
                    end
                end
                StPrep: begin
                    if (bus.kill_i) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        q_q        <= abs_dividend;
                        d_q        <= abs_divisor;
                        r_q        <= 32'd0;
                        cnt_q      <= 5'd0;
                        quot_neg_q <= dividend_q[31] ^ divisor_q[31];
                        rem_neg_q  <= dividend_q[31];
                        if (divisor_q == 32'd0) begin
                            quotient_q  <= DBZ_QUOTIENT;
                            remainder_q <= dividend_q;
                            dbz_q       <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            dbz_q   <= 1'b0;
                            state_q <= StIter;
                        end
                    end
                end
                StIter: begin
                    if (bus.kill_i) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        if (accept) begin
                            r_q <= bus.addsub_result_i;
                            q_q <= {q_q[30:0], 1'b1};
                        end else begin
                            r_q <= shift_s;
                            q_q <= {q_q[30:0], 1'b0};
                        end
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    if (bus.kill_i) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        if (op_signed_q) begin
                            quotient_q  <= quot_neg_q ? -q_q : q_q;
                            remainder_q <= rem_neg_q ? -r_q : r_q;
                        end else begin
                            quotient_q  <= q_q;
                            remainder_q <= r_q;
                        end
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lm32_seq_divider.sv
// Self-checking bench for lm32_seq_divider: directed cases, random operands against an
// arithmetic reference, kill, mid-operation reset and back-to-back starts.
module tb_lm32_seq_divider;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    lm32_seq_divider_if bus ();

    lm32_seq_divider #(
        .DBZ_QUOTIENT(32'hFFFFFFFF)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // External adder/subtractor: Result = A + (Add_Sub ? B : ~B) + Cin.
    logic [32:0] sum;
    always_comb begin
        sum = {1'b0, bus.addsub_a_o}
            + {1'b0, (bus.addsub_add_sub_o ? bus.addsub_b_o : ~bus.addsub_b_o)}
            + {32'd0, bus.addsub_cin_o};
    end
    assign bus.addsub_result_i = sum[31:0];
    assign bus.addsub_cout_i   = sum[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dbz);
        logic [31:0] ua;
        logic [31:0] ub;
        if (b == 32'd0) begin
            q   = 32'hFFFFFFFF;
            r   = a;
            dbz = 1'b1;
            return;
        end
        ua  = (s && a[31]) ? -a : a;
        ub  = (s && b[31]) ? -b : b;
        q   = ua / ub;
        r   = ua % ub;
        if (s && (a[31] ^ b[31])) q = -q;
        if (s && a[31]) r = -r;
        dbz = 1'b0;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy_o || bus.done_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // lat = edges after the accept edge until done_o is seen (34 normal, 1 for divisor 0).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output logic dbz,
                           output int lat);
        wait_idle();
        bus.start_i    = 1'b1;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.signed_i   = s;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat = 0;
        while (!bus.done_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q   = bus.quotient_o;
        r   = bus.remainder_o;
        dbz = bus.dbz_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.dbz_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b dbz=%b required 0 0 0",
                     bus.busy_o, bus.done_o, bus.dbz_o);
        end
        if (bus.quotient_o !== 32'd0 || bus.remainder_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_results q=%h r=%h required 0 0", bus.quotient_o, bus.remainder_o);
        end
        if (bus.addsub_a_o !== 32'd0 || bus.addsub_b_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_addsub_ab a=%h b=%h required 0 0", bus.addsub_a_o, bus.addsub_b_o);
        end
        if (bus.addsub_cin_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_cin got %b required 1", bus.addsub_cin_o);
        end
        if (bus.addsub_add_sub_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_add_sub got %b required 0", bus.addsub_add_sub_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'h1234};
        logic [31:0] vb [6] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'h80000001, 32'hFFFFFFFF, 32'd0};
        logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] eq [6] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd1, 32'h80000000,
                                32'hFFFFFFFF};
        logic [31:0] er [6] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFE, 32'd0, 32'h1234};
        logic        ed [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          el [6] = '{34, 34, 34, 34, 34, 1};
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_div(va[i], vb[i], vs[i], q, r, dbz, lat);
            checks += 3;
            if (q !== eq[i] || r !== er[i] || dbz !== ed[i]) begin
                errors++;
                $display("FAIL directed_%0d q=%h r=%h dbz=%b required %h %h %b",
                         i, q, r, dbz, eq[i], er[i], ed[i]);
            end
            if (lat !== el[i]) begin
                errors++;
                $display("FAIL directed_latency_%0d got %0d required %0d", i, lat, el[i]);
            end
            if (bus.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL directed_busy_in_done_%0d got %b required 0", i, bus.busy_o);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.done_o !== 1'b0 || bus.quotient_o !== eq[i]) begin
                errors++;
                $display("FAIL directed_hold_%0d done=%b q=%h required 0 %h",
                         i, bus.done_o, bus.quotient_o, eq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic [31:0] mq;
        logic [31:0] mr;
        logic        mdbz;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom;
                default: b = (a >> $urandom_range(0, 31)) | 32'd1;
            endcase
            if ($urandom_range(0, 3) == 0) b = -b;
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, mq, mr, mdbz);
            run_div(a, b, s, q, r, dbz, lat);
            checks += 2;
            if (q !== mq || r !== mr || dbz !== mdbz) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h s=%b q=%h r=%h dbz=%b required %h %h %b",
                         i, a, b, s, q, r, dbz, mq, mr, mdbz);
            end
            if (lat !== (mdbz ? 1 : 34)) begin
                errors++;
                $display("FAIL random_latency_%0d got %0d required %0d", i, lat, mdbz ? 1 : 34);
            end
        end
    endtask

    task automatic test_kill();
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          dones;
        run_div(32'd100, 32'd7, 1'b0, q, r, dbz, lat);
        wait_idle();
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'hFFFFFFFD;
        bus.signed_i   = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks += 2;
        if (bus.addsub_b_o !== 32'd3 || bus.addsub_cin_o !== 1'b1 ||
            bus.addsub_add_sub_o !== 1'b0) begin
            errors++;
            $display("FAIL iter_addsub b=%h cin=%b add_sub=%b required 3 1 0",
                     bus.addsub_b_o, bus.addsub_cin_o, bus.addsub_add_sub_o);
        end
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL iter_busy got %b required 1", bus.busy_o);
        end
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'd5;
        bus.divisor_i  = 32'd5;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        bus.kill_i = 1'b1;
        @(posedge clk);
        #1;
        bus.kill_i = 1'b0;
        checks += 2;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_state busy=%b done=%b required 0 0", bus.busy_o, bus.done_o);
        end
        if (bus.quotient_o !== 32'd14 || bus.remainder_o !== 32'd2 || bus.dbz_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_hold q=%h r=%h dbz=%b required e 2 0",
                     bus.quotient_o, bus.remainder_o, bus.dbz_o);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) dones++;
        end
        checks++;
        if (dones !== 0 || bus.quotient_o !== 32'd14) begin
            errors++;
            $display("FAIL kill_no_done dones=%0d q=%h required 0 e", dones, bus.quotient_o);
        end
        // kill in IDLE must block the start
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.kill_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_blocks busy=%b required 0", bus.busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        wait_idle();
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'd999;
        bus.divisor_i  = 32'd10;
        bus.signed_i   = 1'b0;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (21) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 2;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.dbz_o !== 1'b0 ||
            bus.quotient_o !== 32'd0 || bus.remainder_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs busy=%b done=%b dbz=%b q=%h r=%h required all 0",
                     bus.busy_o, bus.done_o, bus.dbz_o, bus.quotient_o, bus.remainder_o);
        end
        if (bus.addsub_a_o !== 32'd0 || bus.addsub_b_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_addsub a=%h b=%h required 0 0",
                     bus.addsub_a_o, bus.addsub_b_o);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d pulses required 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        wait_idle();
        bus.start_i    = 1'b1;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd7;
        bus.signed_i   = 1'b0;
        @(posedge clk);
        #1;
        lat = 0;
        while (!bus.done_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks += 2;
        if (lat !== 34 || bus.quotient_o !== 32'd14) begin
            errors++;
            $display("FAIL b2b_first lat=%0d q=%h required 34 e", lat, bus.quotient_o);
        end
        // start held high: DONE must not accept, the following IDLE cycle must
        bus.dividend_i = 32'hFFFFFFF9;
        bus.divisor_i  = 32'd2;
        bus.signed_i   = 1'b1;
        @(posedge clk);
        #1;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap busy=%b done=%b required 0 0", bus.busy_o, bus.done_o);
        end
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        checks += 2;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept busy=%b required 1", bus.busy_o);
        end
        lat = 0;
        while (!bus.done_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 34 || bus.quotient_o !== 32'hFFFFFFFD || bus.remainder_o !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL b2b_second lat=%0d q=%h r=%h required 34 fffffffd ffffffff",
                     lat, bus.quotient_o, bus.remainder_o);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.kill_i     = 1'b0;
        bus.dividend_i = 32'd0;
        bus.divisor_i  = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
